mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised MEM stage: load/store unit between the EX/MEM and MEM/WB pipeline registers.
//  Byte/half/word loads and stores with sign/zero extension, byte enables and misalignment trap.
//  Talks to a data memory port with variable grant/response latency.
//  Uses valid/ready on both pipeline sides so downstream and memory can stall the core.
//  Non-memory instructions pass through with 1-cycle latency.
// PARAMETERS
//  XLEN    32  data width in bits (32 or 64); the byte-lane count is XLEN/8
//  ADDR_W  32  byte address width
//  SIDE_W  64  width of the passthrough sideband (instruction, pc_plus4, rd_addr, RegWrite, WBSel)
// PORTS
//  clk           in   1         clock, rising edge
//  rst_n         in   1         asynchronous active-low reset
//  in_valid      in   1         EX/MEM entry valid
//  in_ready      out  1         stage accepts the entry this cycle
//  in_mem_read   in   1         load
//  in_mem_write  in   1         store (in_mem_read and in_mem_write both high is illegal: treated as load)
//  in_funct3     in   3         000 B, 001 H, 010 W, 011 D (XLEN=64 only), 100 BU, 101 HU, 110 WU (XLEN=64 only)
//  in_addr       in   ADDR_W    alu_result (effective address)
//  in_wdata      in   XLEN      rs2 data
//  in_side       in   SIDE_W    sideband, forwarded unchanged
//  dmem_req      out  1         memory request
//  dmem_gnt      in   1         request accepted
//  dmem_we       out  1         write request
//  dmem_be       out  XLEN/8    byte enables
//  dmem_addr     out  ADDR_W    address, aligned to XLEN/8 bytes
//  dmem_wdata    out  XLEN      write data, already lane-shifted
//  dmem_rvalid   in   1         read data valid
//  dmem_rdata    in   XLEN      raw read word
//  out_valid     out  1         MEM/WB entry valid
//  out_ready     in   1         WB accepts
//  out_rd_data   out  XLEN      extended load result (0 for non-loads)
//  out_alu_res   out  XLEN      alu_result, zero-extended or truncated to XLEN
//  out_side      out  SIDE_W    registered sideband
//  out_misalign  out  1         access not naturally aligned; no memory request was issued
// BEHAVIOUR
//  Reset: FSM=IDLE. dmem_req, out_valid and out_misalign are 0. All data outputs are 0.
//  States and transitions:
//   IDLE -> REQ on handshake of a memory op.
//   REQ: dmem_req=1 with addr/we/be/wdata held stable until dmem_gnt.
//    Store -> RESP on gnt. Load -> WAIT on gnt.
//   WAIT: capture dmem_rdata on dmem_rvalid -> RESP. rvalid in the same cycle as gnt is not allowed; rvalid is ignored in REQ.
//   RESP: out_valid=1 and outputs held until out_ready -> IDLE.
//  Entry handshake: in_ready = (state==IDLE) && (!out_valid || out_ready).
//  Non-memory op, or misaligned memory op: registered straight to out_valid (1 cycle), no dmem traffic.
//  Misaligned: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
//   out_misalign=1 and out_side still forwarded so WB/trap logic sees the PC.
//  Store lanes: off = addr mod (XLEN/8).
//   be = size mask << off.
//   wdata = in_wdata replicated per size, shifted by 8*off.
//  Load: select bytes at off; sign-extend for B/H/W, zero-extend for BU/HU/WU/D.
//  Minimum latency, grant and rvalid both immediate: store 2 cycles, load 3 cycles, in to out_valid.
//  Back-to-back non-memory ops: 1 per cycle while out_ready=1.
//  Reset mid-transaction: FSM returns to IDLE, dmem_req drops at once, and any late rvalid is ignored.
// TESTING
//  LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF -> out_rd_data 0xDEADBEEF, out_valid on cycle 3.
//  LB addr 0x103, rdata 0x80_00_00_00 -> out_rd_data 0xFFFFFF80; LBU same -> 0x00000080.
//  SH addr 0x102, wdata 0x1234ABCD -> dmem_be 4'b1100, dmem_wdata 0xABCDABCD, dmem_addr 0x100.
//  LW addr 0x101 -> out_misalign=1, dmem_req never asserted, out_valid after 1 cycle.
//  gnt held low 5 cycles, then rvalid 3 cycles later -> dmem_addr stable throughout, in_ready=0, single out_valid.
//  out_ready=0 for 4 cycles in RESP -> out_rd_data held, no new entry accepted.
//  rst_n pulsed low in WAIT -> dmem_req=0 and out_valid=0 immediately; a later rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
// Data-memory port between the MEM-stage load/store unit and data memory.
//   req    : request valid, held with we/be/addr/wdata until gnt
//   gnt    : memory accepts the request this cycle
//   we     : write request
//   be     : byte enables, one per byte lane
//   addr   : byte address aligned to the lane count
//   wdata  : write data, already placed in its lanes
//   rvalid : read data valid (never in the same cycle as gnt)
//   rdata  : raw read word
// Modport master is the load/store unit, modport slave is the memory.
interface mem_stage_lsu_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);
  logic                req;
  logic                gnt;
  logic                we;
  logic [XLEN/8-1:0]   be;
  logic [ADDR_W-1:0]   addr;
  logic [XLEN-1:0]     wdata;
  logic                rvalid;
  logic [XLEN-1:0]     rdata;

  modport master (output req, we, be, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, be, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit between the EX/MEM and MEM/WB registers.
// Byte/half/word(/double) loads and stores with sign/zero extension, byte
// enables and a misalignment trap. Valid/ready on both pipeline sides; the
// memory port tolerates any grant and response latency.
// Ports:
//   clk, rst_n                 clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready        EX/MEM entry handshake
//   in_mem_read, in_mem_write  load / store (both high is treated as a load)
//   in_funct3                  access size and signedness
//   in_addr, in_wdata, in_side effective address, store data, passthrough sideband
//   dmem                       data-memory port (master side)
//   out_valid / out_ready      MEM/WB entry handshake
//   out_rd_data                extended load result (0 for non-loads)
//   out_alu_res                effective address resized to XLEN
//   out_side                   registered sideband
//   out_misalign               access not naturally aligned, no request issued
module mem_stage_lsu #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int SIDE_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [XLEN-1:0]   in_wdata,
  input  logic [SIDE_W-1:0] in_side,
  mem_stage_lsu_if.master   dmem,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_rd_data,
  output logic [XLEN-1:0]   out_alu_res,
  output logic [SIDE_W-1:0] out_side,
  output logic              out_misalign
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int IDX_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  state_t             state_r, state_nxt_s;
  logic               out_valid_r, out_misalign_r;
  logic [XLEN-1:0]    out_rd_data_r, out_alu_res_r;
  logic [SIDE_W-1:0]  out_side_r;
  logic               we_r;
  logic [NB-1:0]      be_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [XLEN-1:0]    wdata_r;
  logic [1:0]         ld_size_r;
  logic               ld_uns_r;
  logic [OFF_W-1:0]   ld_off_r;

  logic               is_mem_s, is_store_s, unaligned_s, misalign_s;
  logic               acc_s, mem_go_s, pass_s;
  logic [OFF_W-1:0]   off_s;
  int                 size_bytes_s;
  logic [NB-1:0]      be_s;
  logic [XLEN-1:0]    wrep_s;
  logic [XLEN-1:0]    rsh_s, ld_ext_s;
  logic [IDX_W-1:0]   msb_s;
  logic               fill_s;
  logic               in_ready_s, dmem_req_s;

  // Decode the incoming entry: alignment, byte enables and lane-placed store data.
  always_comb begin
    is_mem_s     = in_mem_read | in_mem_write;
    is_store_s   = in_mem_write & ~in_mem_read;
    off_s        = in_addr[OFF_W-1:0];
    size_bytes_s = 32'sd1 << in_funct3[1:0];
    case (in_funct3[1:0])
      2'd0:    unaligned_s = 1'b0;
      2'd1:    unaligned_s = in_addr[0];
      2'd2:    unaligned_s = |in_addr[1:0];
      2'd3:    unaligned_s = |in_addr[2:0];
      default: unaligned_s = 1'b0;
    endcase
    misalign_s = is_mem_s & unaligned_s;
    be_s   = '0;
    wrep_s = '0;
    for (int i = 0; i < NB; i++) begin
      be_s[i] = (i >= int'(off_s)) && (i < int'(off_s) + size_bytes_s);
      // Replicating the datum across every lane of its size puts it in the
      // addressed lane for any aligned offset (same as rotating by 8*off).
      wrep_s[8*i +: 8] = in_wdata[8*(i & (size_bytes_s - 32'sd1)) +: 8];
    end
  end

  // Accept conditions: memory ops go through the FSM, everything else (and
  // misaligned memory ops) goes straight to the output register.
  always_comb begin
    acc_s    = in_valid & in_ready_s;
    mem_go_s = acc_s & is_mem_s & ~misalign_s;
    pass_s   = acc_s & ~(is_mem_s & ~misalign_s);
  end

  // Load extraction: shift addressed bytes to lane 0, then sign/zero extend.
  always_comb begin
    rsh_s = dmem.rdata >> {ld_off_r, 3'b000};
    case (ld_size_r)
      2'd0:    msb_s = IDX_W'(32'd7);
      2'd1:    msb_s = IDX_W'(32'd15);
      2'd2:    msb_s = IDX_W'(32'd31);
      default: msb_s = IDX_W'(XLEN - 1);
    endcase
    fill_s   = ~ld_uns_r & rsh_s[msb_s];
    ld_ext_s = '0;
    for (int i = 0; i < XLEN; i++) begin
      ld_ext_s[i] = (i <= int'(msb_s)) ? rsh_s[i] : fill_s;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_nxt_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: if (mem_go_s) state_nxt_s = REQ; else state_nxt_s = IDLE;
      REQ:  if (dmem.gnt) state_nxt_s = we_r ? RESP : WAIT; else state_nxt_s = REQ;
      WAIT: if (dmem.rvalid) state_nxt_s = RESP; else state_nxt_s = WAIT;
      RESP: if (out_ready) state_nxt_s = IDLE; else state_nxt_s = RESP;
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: request strobe and entry-side ready.
  always_comb begin
    dmem_req_s = (state_r == REQ);
    in_ready_s = (state_r == IDLE) && (!out_valid_r || out_ready);
  end

  // Output and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r    <= 1'b0;
      out_misalign_r <= 1'b0;
      out_rd_data_r  <= '0;
      out_alu_res_r  <= '0;
      out_side_r     <= '0;
      we_r           <= 1'b0;
      be_r           <= '0;
      addr_r         <= '0;
      wdata_r        <= '0;
      ld_size_r      <= 2'd0;
      ld_uns_r       <= 1'b0;
      ld_off_r       <= '0;
    end else begin
      if (acc_s) begin
        out_alu_res_r  <= XLEN'(in_addr);
        out_side_r     <= in_side;
        out_misalign_r <= misalign_s;
        out_rd_data_r  <= '0;
      end else if (state_r == WAIT && dmem.rvalid) begin
        out_rd_data_r  <= ld_ext_s;
      end
      if (mem_go_s) begin
        we_r      <= is_store_s;
        be_r      <= be_s;
        addr_r    <= {in_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
        wdata_r   <= wrep_s;
        ld_size_r <= in_funct3[1:0];
        ld_uns_r  <= in_funct3[2] | (in_funct3[1:0] == 2'd3);
        ld_off_r  <= off_s;
      end
      if (pass_s)                                  out_valid_r <= 1'b1;
      else if (state_r == REQ && dmem.gnt && we_r) out_valid_r <= 1'b1;
      else if (state_r == WAIT && dmem.rvalid)     out_valid_r <= 1'b1;
      else if (out_ready)                          out_valid_r <= 1'b0;
    end
  end

  assign in_ready     = in_ready_s;
  assign dmem.req     = dmem_req_s;
  assign dmem.we      = we_r;
  assign dmem.be      = be_r;
  assign dmem.addr    = addr_r;
  assign dmem.wdata   = wdata_r;
  assign out_valid    = out_valid_r;
  assign out_misalign = out_misalign_r;
  assign out_rd_data  = out_rd_data_r;
  assign out_alu_res  = out_alu_res_r;
  assign out_side     = out_side_r;
endmodule
